// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one add/sub ALU pipeline among NREQ requesters.
// Arbitrates requests onto the ALU, follows requester ids through the ALU
// latency with a tag shift register, and buffers results in a response FIFO.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; without it
// the arbiter is fixed priority (lowest index wins).
module alu_arbiter #(
   parameter int WIDTH      = 8,
   parameter int NREQ       = 4,
   parameter int ALU_LAT    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [2*NREQ-1:0]         req_op,
   input  logic [WIDTH*NREQ-1:0]     req_a,
   input  logic [WIDTH*NREQ-1:0]     req_b,
   output logic [1:0]                alu_op,
   output logic [WIDTH-1:0]          alu_a,
   output logic [WIDTH-1:0]          alu_b,
   output logic                      alu_in_valid,
   input  logic [WIDTH-1:0]          alu_out,
   input  logic                      alu_out_valid,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [$clog2(NREQ)-1:0]   resp_id,
   output logic [WIDTH-1:0]          resp_data,
   output logic                      err
);

   localparam int IDW  = $clog2(NREQ);
   localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CFW  = $clog2(FIFO_DEPTH + 1);
   localparam int CNTW = $clog2(FIFO_DEPTH + ALU_LAT + 1) + 1;

   logic                found;
   logic [IDW-1:0]      winner;
   logic [IDW-1:0]      cand;
   logic                credit_ok;
   logic                transfer;

   logic [ALU_LAT-1:0]  tag_valid;
   logic [IDW-1:0]      tag_id [ALU_LAT];
   logic [CNTW-1:0]     outstanding;

   logic [WIDTH-1:0]    fifo_data [FIFO_DEPTH];
   logic [IDW-1:0]      fifo_id [FIFO_DEPTH];
   logic [PW-1:0]       head;
   logic [PW-1:0]       tail;
   logic [CFW-1:0]      count;
   logic                full;
   logic                push;
   logic                pop;
   logic                mismatch;
   logic                overflow;

   // FIFO pointers wrap explicitly so non-power-of-two depths work
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

`ifdef ALU_ARB_RR_EN
   logic [IDW-1:0] rr_ptr;

   // Round-robin pick: first valid requester at or after rr_ptr
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'((int'(rr_ptr) + k) % NREQ);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Pointer moves just past the winner on every accepted request
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         rr_ptr <= '0;
      else if (transfer)
         rr_ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + IDW'(1);
   end
`else
   // Fixed-priority pick: lowest valid index wins
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'(k);
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end
`endif

   // Credit: every op in the ALU or waiting in the FIFO holds one FIFO slot
   always_comb begin
      outstanding = '0;
      for (int s = 0; s < ALU_LAT; s++)
         outstanding = outstanding + CNTW'(tag_valid[s]);
      credit_ok = (outstanding + CNTW'(count)) < CNTW'(FIFO_DEPTH);
      transfer  = found & credit_ok & ~rst;
   end

   // Grant and ALU drive; everything idles to zero when nothing transfers
   always_comb begin
      req_ready    = '0;
      alu_in_valid = 1'b0;
      alu_op       = 2'd0;
      alu_a        = '0;
      alu_b        = '0;
      if (transfer) begin
         req_ready[winner] = 1'b1;
         alu_in_valid      = 1'b1;
         alu_op            = req_op[int'(winner)*2 +: 2];
         alu_a             = req_a[int'(winner)*WIDTH +: WIDTH];
         alu_b             = req_b[int'(winner)*WIDTH +: WIDTH];
      end
   end

   // Tag shift register carries requester ids in step with the ALU pipeline
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_valid <= '0;
         for (int s = 0; s < ALU_LAT; s++)
            tag_id[s] <= '0;
      end else begin
         tag_valid[0] <= transfer;
         tag_id[0]    <= winner;
         for (int s = 1; s < ALU_LAT; s++) begin
            tag_valid[s] <= tag_valid[s-1];
            tag_id[s]    <= tag_id[s-1];
         end
      end
   end

   // Capture and error qualification at the ALU output
   always_comb begin
      full     = (count == CFW'(FIFO_DEPTH));
      mismatch = tag_valid[ALU_LAT-1] ^ alu_out_valid;
      overflow = tag_valid[ALU_LAT-1] & alu_out_valid & full;
      push     = tag_valid[ALU_LAT-1] & alu_out_valid & ~full;
      pop      = resp_valid & resp_ready;
   end

   // Response FIFO storage, pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int e = 0; e < FIFO_DEPTH; e++) begin
            fifo_data[e] <= '0;
            fifo_id[e]   <= '0;
         end
      end else begin
         if (push) begin
            fifo_data[tail] <= alu_out;
            fifo_id[tail]   <= tag_id[ALU_LAT-1];
            tail            <= ptr_next(tail);
         end
         if (pop)
            head <= ptr_next(head);
         if (push && !pop)
            count <= count + CFW'(1);
         else if (!push && pop)
            count <= count - CFW'(1);
      end
   end

   // Sticky error on tag/result misalignment or a push into a full FIFO
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err <= 1'b0;
      else if (mismatch || overflow)
         err <= 1'b1;
   end

   assign resp_valid = (count != '0);
   assign resp_id    = resp_valid ? fifo_id[head] : '0;
   assign resp_data  = resp_valid ? fifo_data[head] : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized self-checking bench for alu_arbiter, with a
// 2-cycle add/sub ALU model and a queue-based reference of expected responses.
module tb_alu_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [7:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [1:0]  alu_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic        alu_in_valid;
   logic [7:0]  alu_out;
   logic        alu_out_valid;
   logic        resp_valid;
   logic        resp_ready;
   logic [1:0]  resp_id;
   logic [7:0]  resp_data;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [1:0] id;
      logic [7:0] data;
   } resp_t;

   resp_t exp_q[$];
   int    rr_m = 0;

   alu_arbiter #(.WIDTH(8), .NREQ(4), .ALU_LAT(2), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_in_valid(alu_in_valid),
      .alu_out(alu_out), .alu_out_valid(alu_out_valid),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_data(resp_data), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two-stage add/sub ALU sharing the arbiter's clock and reset
   logic       s1v, s2v, force_alu_valid;
   logic [7:0] s1r, s2r;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1v <= 1'b0; s2v <= 1'b0; s1r <= 8'h00; s2r <= 8'h00;
      end else begin
         s1v <= alu_in_valid;
         s1r <= (alu_op == 2'd1) ? alu_a + alu_b : (alu_op == 2'd2) ? alu_a - alu_b : 8'h00;
         s2v <= s1v;
         s2r <= s1r;
      end
   end
   assign alu_out_valid = s2v | force_alu_valid;
   assign alu_out       = s2r;

   function automatic logic [7:0] calc(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'd1:    return a + b;
         2'd2:    return a - b;
         default: return 8'h00;
      endcase
   endfunction

   // Which requester should win now: none if 4 ops are already unreturned
   function automatic int model_pick(input logic [3:0] v);
      int idx;
      if (exp_q.size() >= 4) return -1;
      for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
         idx = (rr_m + k) % 4;
`else
         idx = k;
`endif
         if (v[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   task automatic clear_req();
      req_valid = 4'h0; req_op = 8'h00; req_a = 32'h0; req_b = 32'h0;
   endtask

   task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      req_valid[i] = 1'b1;
      req_op[i*2 +: 2] = op;
      req_a[i*8 +: 8]  = a;
      req_b[i*8 +: 8]  = b;
   endtask

   // Samples one cycle at the falling edge and advances the reference model
   task automatic observe(output int ep, output int gp, output bit pp, output bit pe,
                          output logic [1:0] eid, output logic [7:0] ed);
      resp_t e;
      @(negedge clk);
      ep = model_pick(req_valid);
      gp = -1;
      if (req_ready != 4'h0) gp = $onehot(req_ready) ? $clog2(req_ready) : -2;
      pp = resp_valid && resp_ready;
      pe = 1'b0; eid = 2'd0; ed = 8'h00;
      if (pp) begin
         if (exp_q.size() == 0) pe = 1'b1;
         else begin
            e = exp_q.pop_front();
            eid = e.id; ed = e.data;
         end
      end
      if (ep >= 0) begin
         e.id   = 2'(ep);
         e.data = calc(req_op[ep*2 +: 2], req_a[ep*8 +: 8], req_b[ep*8 +: 8]);
         exp_q.push_back(e);
`ifdef ALU_ARB_RR_EN
         rr_m = (ep + 1) % 4;
`endif
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; force_alu_valid = 1'b0; resp_ready = 1'b1;
      req_valid = 4'hF; req_op = 8'($urandom); req_a = $urandom; req_b = $urandom;
      #2;
      n_cmp++;
      if ({req_ready, alu_in_valid, alu_op, alu_a, alu_b, resp_valid, resp_id, resp_data, err} !== '0)
         begin n_bad++; $display("[TB] FAIL reset_outputs: got ready=%h aiv=%b rv=%b err=%b expected all 0", req_ready, alu_in_valid, resp_valid, err); end
      @(negedge clk); #1;
      rst = 1'b0; clear_req(); exp_q.delete(); rr_m = 0;
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b0 || err !== 1'b0)
         begin n_bad++; $display("[TB] FAIL reset_release: got resp_valid=%b err=%b expected 0 0", resp_valid, err); end
   endtask

   task automatic test_single();
      int ep, gp, first; bit pp, pe; logic [1:0] eid; logic [7:0] ed;
      first = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         clear_req(); resp_ready = 1'b1;
         if (c == 0) set_req(0, 2'd1, 8'd3, 8'd4);
         observe(ep, gp, pp, pe, eid, ed);
         if (c == 0) begin
            n_cmp++;
            if (gp !== 0 || alu_in_valid !== 1'b1 || alu_op !== 2'd1 || alu_a !== 8'd3 || alu_b !== 8'd4)
               begin n_bad++; $display("[TB] FAIL single_issue: got grant=%0d aiv=%b op=%0d a=%0d b=%0d expected 0 1 1 3 4", gp, alu_in_valid, alu_op, alu_a, alu_b); end
         end
         if (pp && first == 0) begin
            first = c;
            n_cmp++;
            if (resp_id !== 2'd0 || resp_data !== 8'd7)
               begin n_bad++; $display("[TB] FAIL single_resp: got id=%0d data=%h expected 0 07", resp_id, resp_data); end
         end
      end
      n_cmp++;
      if (first != 3)
         begin n_bad++; $display("[TB] FAIL single_latency: got %0d cycles expected 3", first); end
   endtask

   task automatic test_wrap_sub();
      int ep, gp, npop; bit pp, pe; logic [1:0] eid; logic [7:0] ed;
      logic [1:0] kid [2];
      logic [7:0] kd [2];
      kid[0] = 2'd2; kd[0] = 8'hFC; kid[1] = 2'd1; kd[1] = 8'h01;
      npop = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         clear_req(); resp_ready = 1'b1;
         if (c == 0) set_req(2, 2'd2, 8'd5, 8'd9);
         if (c == 1) set_req(1, 2'd1, 8'hFF, 8'h02);
         observe(ep, gp, pp, pe, eid, ed);
         if (pp) begin
            n_cmp++;
            if (npop > 1 || resp_id !== kid[npop] || resp_data !== kd[npop])
               begin n_bad++; $display("[TB] FAIL wrap_resp: got id=%0d data=%h expected id=%0d data=%h", resp_id, resp_data, kid[npop & 1], kd[npop & 1]); end
            npop++;
         end
      end
      n_cmp++;
      if (npop != 2)
         begin n_bad++; $display("[TB] FAIL wrap_count: got %0d responses expected 2", npop); end
   endtask

   task automatic test_contention();
      int ep, gp; bit pp, pe; logic [1:0] eid; logic [7:0] ed;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         clear_req(); resp_ready = 1'b1;
         for (int i = 0; i < 4; i++) set_req(i, 2'($urandom_range(1, 2)), 8'($urandom), 8'($urandom));
         observe(ep, gp, pp, pe, eid, ed);
         n_cmp++;
         if (gp !== ep || gp < 0)
            begin n_bad++; $display("[TB] FAIL contention_grant: got %0d expected %0d", gp, ep); end
         if (pp) begin
            n_cmp++;
            if (pe || resp_id !== eid || resp_data !== ed)
               begin n_bad++; $display("[TB] FAIL contention_resp: got id=%0d data=%h expected id=%0d data=%h", resp_id, resp_data, eid, ed); end
         end
      end
      for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
         @(posedge clk); #1;
         clear_req();
         observe(ep, gp, pp, pe, eid, ed);
         if (pp) begin
            n_cmp++;
            if (pe || resp_id !== eid || resp_data !== ed)
               begin n_bad++; $display("[TB] FAIL contention_drain: got id=%0d data=%h expected id=%0d data=%h", resp_id, resp_data, eid, ed); end
         end
      end
      n_cmp++;
      if (exp_q.size() != 0)
         begin n_bad++; $display("[TB] FAIL contention_timeout: got %0d pending expected 0", exp_q.size()); end
   endtask

   task automatic test_backpressure();
      int ep, gp, acc, npop; bit pp, pe, resumed; logic [1:0] eid; logic [7:0] ed;
      acc = 0; npop = 0; resumed = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         clear_req(); resp_ready = 1'b0;
         set_req(c % 4, 2'd1, 8'($urandom), 8'($urandom));
         observe(ep, gp, pp, pe, eid, ed);
         if (gp >= 0) acc++;
         n_cmp++;
         if (gp !== ep)
            begin n_bad++; $display("[TB] FAIL bp_grant: got %0d expected %0d", gp, ep); end
      end
      n_cmp++;
      if (acc != 4)
         begin n_bad++; $display("[TB] FAIL bp_accepted: got %0d expected 4", acc); end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         clear_req(); resp_ready = 1'b1;
         set_req(3, 2'd2, 8'($urandom), 8'($urandom));
         observe(ep, gp, pp, pe, eid, ed);
         if (gp >= 0) resumed = 1'b1;
         n_cmp++;
         if (gp !== ep)
            begin n_bad++; $display("[TB] FAIL bp_resume_grant: got %0d expected %0d", gp, ep); end
         if (pp) begin
            npop++;
            n_cmp++;
            if (pe || resp_id !== eid || resp_data !== ed)
               begin n_bad++; $display("[TB] FAIL bp_resp: got id=%0d data=%h expected id=%0d data=%h", resp_id, resp_data, eid, ed); end
         end
      end
      n_cmp++;
      if (npop < 4 || !resumed)
         begin n_bad++; $display("[TB] FAIL bp_drain: got pops=%0d resumed=%b expected >=4 1", npop, resumed); end
      for (int c = 0; c < 12 && exp_q.size() > 0; c++) begin
         @(posedge clk); #1;
         clear_req();
         observe(ep, gp, pp, pe, eid, ed);
         if (pp) begin
            n_cmp++;
            if (pe || resp_id !== eid || resp_data !== ed)
               begin n_bad++; $display("[TB] FAIL bp_final: got id=%0d data=%h expected id=%0d data=%h", resp_id, resp_data, eid, ed); end
         end
      end
      n_cmp++;
      if (exp_q.size() != 0)
         begin n_bad++; $display("[TB] FAIL bp_timeout: got %0d pending expected 0", exp_q.size()); end
   endtask

   task automatic test_reset_midop();
      int ep, gp, npop; bit pp, pe; logic [1:0] eid; logic [7:0] ed;
      npop = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         clear_req(); resp_ready = 1'b0;
         if (c == 0 || c == 4 || c == 5) set_req(3, 2'd1, 8'($urandom), 8'($urandom));
         observe(ep, gp, pp, pe, eid, ed);
         n_cmp++;
         if (gp !== ep)
            begin n_bad++; $display("[TB] FAIL midop_grant: got %0d expected %0d", gp, ep); end
      end
      @(posedge clk); #1;
      n_cmp++;
      if (resp_valid !== 1'b1)
         begin n_bad++; $display("[TB] FAIL midop_buffered: got resp_valid=%b expected 1", resp_valid); end
      req_valid = 4'hF; req_op = 8'h55; req_a = $urandom; req_b = $urandom; resp_ready = 1'b1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({req_ready, alu_in_valid, alu_op, alu_a, alu_b, resp_valid, resp_id, resp_data, err} !== '0)
         begin n_bad++; $display("[TB] FAIL midop_reset_outputs: got ready=%h aiv=%b rv=%b data=%h expected all 0", req_ready, alu_in_valid, resp_valid, resp_data); end
      exp_q.delete(); rr_m = 0;
      @(negedge clk); #1;
      rst = 1'b0; clear_req();
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         clear_req();
         observe(ep, gp, pp, pe, eid, ed);
         n_cmp++;
         if (resp_valid !== 1'b0)
            begin n_bad++; $display("[TB] FAIL midop_stale: got resp_valid=%b expected 0", resp_valid); end
      end
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         clear_req();
         if (c == 0) set_req(1, 2'd2, 8'($urandom), 8'($urandom));
         observe(ep, gp, pp, pe, eid, ed);
         if (pp) begin
            npop++;
            n_cmp++;
            if (pe || resp_id !== eid || resp_data !== ed)
               begin n_bad++; $display("[TB] FAIL midop_next: got id=%0d data=%h expected id=%0d data=%h", resp_id, resp_data, eid, ed); end
         end
      end
      n_cmp++;
      if (npop != 1)
         begin n_bad++; $display("[TB] FAIL midop_count: got %0d responses expected 1", npop); end
   endtask

   task automatic test_random();
      int ep, gp; bit pp, pe; logic [1:0] eid; logic [7:0] ed;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         clear_req();
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 1) == 1) set_req(i, 2'($urandom_range(0, 2)), 8'($urandom), 8'($urandom));
         resp_ready = ($urandom_range(0, 3) != 0);
         observe(ep, gp, pp, pe, eid, ed);
         n_cmp++;
         if (gp !== ep || alu_in_valid !== (ep >= 0))
            begin n_bad++; $display("[TB] FAIL random_grant: got %0d aiv=%b expected %0d", gp, alu_in_valid, ep); end
         if (ep >= 0) begin
            n_cmp++;
            if (alu_op !== req_op[ep*2 +: 2] || alu_a !== req_a[ep*8 +: 8] || alu_b !== req_b[ep*8 +: 8])
               begin n_bad++; $display("[TB] FAIL random_alu_drive: got op=%0d a=%h b=%h expected op=%0d a=%h b=%h", alu_op, alu_a, alu_b, req_op[ep*2 +: 2], req_a[ep*8 +: 8], req_b[ep*8 +: 8]); end
         end
         if (pp) begin
            n_cmp++;
            if (pe || resp_id !== eid || resp_data !== ed)
               begin n_bad++; $display("[TB] FAIL random_resp: got id=%0d data=%h expected id=%0d data=%h", resp_id, resp_data, eid, ed); end
         end
      end
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
         @(posedge clk); #1;
         clear_req(); resp_ready = 1'b1;
         observe(ep, gp, pp, pe, eid, ed);
         if (pp) begin
            n_cmp++;
            if (pe || resp_id !== eid || resp_data !== ed)
               begin n_bad++; $display("[TB] FAIL random_drain: got id=%0d data=%h expected id=%0d data=%h", resp_id, resp_data, eid, ed); end
         end
      end
      n_cmp++;
      if (exp_q.size() != 0)
         begin n_bad++; $display("[TB] FAIL random_timeout: got %0d pending expected 0", exp_q.size()); end
   endtask

   task automatic test_error();
      @(posedge clk); #1;
      clear_req(); resp_ready = 1'b1;
      n_cmp++;
      if (err !== 1'b0)
         begin n_bad++; $display("[TB] FAIL err_before: got %b expected 0", err); end
      force_alu_valid = 1'b1;
      @(posedge clk); #1;
      force_alu_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_cmp++;
         if (err !== 1'b1 || resp_valid !== 1'b0)
            begin n_bad++; $display("[TB] FAIL err_sticky: got err=%b resp_valid=%b expected 1 0", err, resp_valid); end
      end
   endtask

   // Guards against a hung run
   initial begin
      #200000;
      n_bad++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      clear_req();
      resp_ready = 1'b0;
      force_alu_valid = 1'b0;
      rst = 1'b1;
      test_reset();
      test_single();
      test_wrap_sub();
      test_contention();
      test_backpressure();
      test_reset_midop();
      test_random();
      test_error();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
